// File: rtl/sum_pkg.sv
// Shared constants and state type for the operand loader and the summer it feeds.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sum_pkg;

    localparam int SUM_N       = 30;  // operands per frame
    localparam int SUM_W       = 5;   // operand width in bits
    localparam int SUM_TIMEOUT = 16;  // max cycles from start to sum_done

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } sum_state_t;

    // Width of an index that counts 0..n-1; never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sum_operand_loader_if.sv
// Upstream word stream plus summer handshake for the operand loader.
// Latency: n/a (wires only).
// Backpressure: upstream is stalled by in_ready; the summer releases operands via sum_done.
interface sum_operand_loader_if
    import sum_pkg::*;
#(
    parameter int N = SUM_N,
    parameter int W = SUM_W
);
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic           in_ready;
    logic [N*W-1:0] num_bus;
    logic           start;
    logic           sum_done;
    logic           frame_err;
    logic           timeout;
    logic [7:0]     frame_cnt;

    // Driver side: upstream source and summer.
    modport master (
        output in_valid, in_data, in_last, sum_done,
        input  in_ready, num_bus, start, frame_err, timeout, frame_cnt
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data, in_last, sum_done,
        output in_ready, num_bus, start, frame_err, timeout, frame_cnt
    );
endinterface

// File: rtl/sum_watchdog.sv
// Counts cycles while enabled and flags the cycle the count reaches TIMEOUT-1.
// Latency: expire is combinational from the registered count, TIMEOUT-1 cycles after enable rises.
// Backpressure: none; the counter clears whenever disabled or expiring.
module sum_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expire = en && (cnt == CW'(TIMEOUT - 1));

    // Count up while enabled; restart from zero on every fresh enable.
    always_ff @(posedge clk) begin
        if (rst || !en || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/sum_operand_loader.sv
// Collects N operand words into registered slots, launches the summer, waits for sum_done.
// Latency: start one cycle after the last-word transfer; minimum start spacing N+2 cycles.
// Backpressure: in_ready only in FILL; operands are frozen until sum_done or watchdog expiry.
module sum_operand_loader
    import sum_pkg::*;
#(
    parameter int N       = SUM_N,
    parameter int W       = SUM_W,
    parameter int TIMEOUT = SUM_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    sum_operand_loader_if.slave  bus
);
    localparam int IW = idx_bits(N);

    sum_state_t     state;
    sum_state_t     state_nxt;
    logic [IW-1:0]  idx;
    logic [N*W-1:0] num_q;
    logic           frame_err_q;
    logic [7:0]     frame_cnt_q;
    logic           ready_c;
    logic           start_c;
    logic           timeout_c;
    logic           xfer;
    logic           at_end;
    logic           wd_en;
    logic           wd_expire;

    assign at_end = (idx == IW'(N - 1));
    assign xfer   = bus.in_valid && ready_c;
    assign wd_en  = (state == WAIT);

    sum_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-state strobes; every strobe is suppressed while in reset.
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        start_c   = 1'b0;
        timeout_c = 1'b0;
        case (state)
            FILL: begin
                ready_c = !rst;
                if (bus.in_valid && at_end && bus.in_last) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                start_c   = !rst;
                state_nxt = WAIT;
            end
            WAIT: begin
                // sum_done takes priority over an expiry in the same cycle.
                if (bus.sum_done) begin
                    state_nxt = FILL;
                end else if (wd_expire) begin
                    timeout_c = !rst;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Operand slots, slot index, framing error pulse and launch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            num_q       <= '0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            frame_err_q <= 1'b0;
            if (xfer) begin
                num_q[int'(idx)*W +: W] <= bus.in_data;
                // A frame ends on in_last or on the final slot; it is only
                // well formed when both happen together.
                if (at_end || bus.in_last) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
                if (at_end != bus.in_last) begin
                    frame_err_q <= 1'b1;
                end
            end
            if (state == LAUNCH) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.start     = start_c;
    assign bus.timeout   = timeout_c;
    assign bus.frame_err = frame_err_q && !rst;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.num_bus   = num_q;
endmodule

// File: doc/sum_operand_loader.md
SUM_OPERAND_LOADER -- requirements
Module: sum_operand_loader

Interface
REQ-001 SHALL have parameter N, default 30: operands per frame.
REQ-002 SHALL have parameter W, default 5: operand width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum cycles from start to sum_done.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream word valid.
REQ-007 SHALL have port in_data  input  W  operand value.
REQ-008 SHALL have port in_last  input  1  marks final word of a frame.
REQ-009 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port num_bus  output  N*W  operands; slot k (0-based) at bits [k*W+W-1 : k*W]; slot 0 feeds the summer's first operand.
REQ-011 SHALL have port start  output  1  one-cycle pulse telling the summer to begin.
REQ-012 SHALL have port sum_done  input  1  summer finished; operands may change.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on a malformed frame.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse when sum_done does not arrive in time.
REQ-015 SHALL have port frame_cnt  output  8  count of launched frames; wraps 255 -> 0.

Function
REQ-016 SHALL implement states FILL, LAUNCH and WAIT.
REQ-017 In FILL, in_ready SHALL be 1; in all other states, and while rst=1, in_ready SHALL be 0.
REQ-018 A word SHALL transfer only when in_valid=1 and in_ready=1; it SHALL be written to slot idx, then idx SHALL increment.
REQ-019 When a transfer has idx=N-1 and in_last=1, the state SHALL go FILL -> LAUNCH and idx SHALL return to 0.
REQ-020 On a transfer with in_last=1 and idx<N-1, frame_err SHALL pulse the next cycle, idx SHALL return to 0 and the state SHALL stay FILL; slots already written are not cleared.
REQ-021 On a transfer with idx=N-1 and in_last=0, frame_err SHALL pulse, the frame SHALL be discarded, idx SHALL return to 0 and the state SHALL stay FILL.
REQ-022 In LAUNCH, start SHALL be 1 for exactly that cycle, frame_cnt SHALL increment, and the state SHALL go to WAIT.
REQ-023 sum_done SHALL be ignored in FILL and LAUNCH.
REQ-024 In WAIT, num_bus SHALL be held constant.
REQ-025 In WAIT, sum_done=1 SHALL return the state to FILL the next cycle, so in_ready=1 that cycle.
REQ-026 In WAIT, a cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT-1 without sum_done, timeout SHALL pulse and the state SHALL return to FILL.
REQ-027 If sum_done arrives in the same cycle that the timeout expires, sum_done SHALL win and no timeout pulse SHALL occur.
REQ-028 Latency SHALL be 1 cycle from the last-word transfer to start=1.
REQ-029 The minimum spacing between start pulses SHALL be N+2 cycles.
REQ-030 num_bus SHALL be driven directly from registers, with no combinational path from in_data.

Reset
REQ-031 With rst=1 at a clock edge, the block SHALL enter FILL with idx=0 and the WAIT counter at 0.
REQ-032 The same reset SHALL clear all slots to 0 and set start=0, frame_err=0, timeout=0 and frame_cnt=0.
REQ-033 A reset mid-frame or during WAIT SHALL abandon the frame with no start, frame_err or timeout pulse.

Structure
REQ-034 N, W, TIMEOUT and the state enum SHALL live in shared package sum_pkg, which the summer also uses.
REQ-035 The TIMEOUT watchdog SHALL be one sub-module, sum_watchdog (counter, enable, expire pulse).
REQ-036 Expected RTL size is 150-250 lines.

Verification
REQ-037 Scenario: 30 words of value 31, in_last on the 30th, in_valid held high -> start pulses 1 cycle after the 30th transfer; num_bus is all ones (150 bits); frame_cnt=1.
REQ-038 Scenario: in_last on the 12th word -> frame_err pulses once, no start, and the next 30-word frame launches normally.
REQ-039 Scenario: 30 words with no in_last -> frame_err pulses; the 31st word is accepted into slot 0.
REQ-040 Scenario: frame launched and sum_done held 0 -> timeout pulses 16 cycles after start, then in_ready=1.
REQ-041 Scenario: sum_done pulsed 9 cycles after start -> num_bus is unchanged throughout WAIT; in_ready=1 on the cycle after sum_done.
REQ-042 Scenario: rst asserted after 20 words -> no pulses; frame_cnt=0; a fresh 30-word frame launches with slot 0 holding the first new word.
